// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Packs LANES consecutive DATA_W-bit bytes from a valid/ready byte
//            stream into one wide word with per-lane keep bits and a
//            packet-end flag. A byte flagged w_last flushes a partial word.
//            The wide output is a registered valid/ready port.
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            w_valid/w_ready       - byte-side handshake
//            w_data, w_last        - byte and end-of-packet marker
//            r_valid/r_ready       - word-side handshake
//            r_data, r_keep, r_last- packed word (lane 0 = low bits), lane
//                                    valid mask, word-ends-packet flag
//            busy                  - partial word held in the assembly buffer
// Revision : 1.0  initial release
// ============================================================================
module byte_packer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      w_ready,
  input  logic                      w_valid,
  input  logic [DATA_W-1:0]         w_data,
  input  logic                      w_last,
  input  logic                      r_ready,
  output logic                      r_valid,
  output logic [LANES*DATA_W-1:0]   r_data,
  output logic [LANES-1:0]          r_keep,
  output logic                      r_last,
  output logic                      busy
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [LANES*DATA_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic                    accept;
  logic                    complete;
  logic [LANES*DATA_W-1:0] merged;
  logic [LANES-1:0]        keep_mask;

  // Intake stalls whenever the output word cannot move, independent of what
  // the upstream is presenting.
  assign w_ready  = !r_valid || r_ready;
  assign accept   = w_valid && w_ready;
  assign complete = accept && ((cnt == LAST_LANE) || w_last);
  assign busy     = (cnt != '0);

  // Buffer contents with the incoming byte dropped into lane cnt. Lanes above
  // cnt are forced to zero so a flushed partial word carries no stale bytes.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [CNT_W-1:0] LANE_IDX = CNT_W'(k);
    assign merged[k*DATA_W +: DATA_W] =
        (LANE_IDX <  cnt) ? acc[k*DATA_W +: DATA_W] :
        (LANE_IDX == cnt) ? w_data                  :
                            '0;
    assign keep_mask[k] = (LANE_IDX <= cnt);
  end

  // Assembly buffer and lane counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= merged;
      cnt <= cnt + 1'b1;
    end
  end

  // Output register. A completion on the same edge as a drain replaces the
  // outgoing word, keeping r_valid high for full throughput.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (complete) begin
      r_valid <= 1'b1;
      r_data  <= merged;
      r_keep  <= keep_mask;
      r_last  <= w_last;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_packer
// Purpose  : Self-checking bench for byte_packer (LANES=4, DATA_W=8).
//            Directed scenarios plus a randomized run scored against a
//            packet-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_byte_packer;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    w_ready;
  logic                    w_valid = 1'b0;
  logic [DATA_W-1:0]       w_data  = '0;
  logic                    w_last  = 1'b0;
  logic                    r_ready = 1'b0;
  logic                    r_valid;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES-1:0]        r_keep;
  logic                    r_last;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  // Outputs captured on the falling edge, i.e. the values that the next
  // rising edge will act upon.
  logic                    s_ready, s_valid, s_last, s_busy;
  logic [LANES*DATA_W-1:0] s_data;
  logic [LANES-1:0]        s_keep;

  byte_packer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .w_ready(w_ready),
    .w_valid(w_valid),
    .w_data (w_data),
    .w_last (w_last),
    .r_ready(r_ready),
    .r_valid(r_valid),
    .r_data (r_data),
    .r_keep (r_keep),
    .r_last (r_last),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, capture outputs at the falling edge, then
  // advance to just after the next rising edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d,
                             input logic l, input logic rr);
    w_valid = v;
    w_data  = d;
    w_last  = l;
    r_ready = rr;
    @(negedge clock);
    s_ready = w_ready;
    s_valid = r_valid;
    s_data  = r_data;
    s_keep  = r_keep;
    s_last  = r_last;
    s_busy  = busy;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (s_valid !== 1'b0 || s_data !== '0 || s_keep !== '0 || s_last !== 1'b0 ||
        s_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h keep=%h last=%b busy=%b required all zero",
               s_valid, s_data, s_keep, s_last, s_busy);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: w_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_full_word();
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h22, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h33, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h44, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h44332211 || s_keep !== 4'hF || s_last !== 1'b0) begin
      failures++;
      $display("FAIL full_word: valid=%b data=%h keep=%h last=%b required 1 44332211 f 0",
               s_valid, s_data, s_keep, s_last);
    end
  endtask

  task automatic test_partial();
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'hBB, 1'b1, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h0000BBAA || s_keep !== 4'h3 || s_last !== 1'b1) begin
      failures++;
      $display("FAIL partial_word: valid=%b data=%h keep=%h last=%b required 1 0000bbaa 3 1",
               s_valid, s_data, s_keep, s_last);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL partial_after: busy=%b valid=%b required 0 0", s_busy, s_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) drive_cycle(1'b1, 8'(k + 1), 1'b0, 1'b1);
      else        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready cycle %0d: w_ready=%b required 1", k, s_ready);
      end
      checks++;
      if (s_valid !== ((k % 4 == 0) && k != 0)) begin
        failures++;
        $display("FAIL b2b_valid cycle %0d: r_valid=%b required %b", k, s_valid,
                 (k % 4 == 0) && k != 0);
      end
      if (k != 0 && k % 4 == 0) begin
        exp_w = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
        checks++;
        if (s_data !== exp_w || s_keep !== 4'hF || s_last !== 1'b0) begin
          failures++;
          $display("FAIL b2b_word cycle %0d: data=%h keep=%h last=%b required %h f 0",
                   k, s_data, s_keep, s_last, exp_w);
        end
      end
    end
  endtask

  task automatic test_stall();
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h22, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h33, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h44, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
      checks++;
      if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_data !== 32'h44332211 || s_keep !== 4'hF) begin
        failures++;
        $display("FAIL stall_hold %0d: ready=%b valid=%b data=%h keep=%h required 0 1 44332211 f",
                 k, s_ready, s_valid, s_data, s_keep);
      end
    end
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b1);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: w_ready=%b required 1", s_ready);
    end
    drive_cycle(1'b1, 8'h66, 1'b1, 1'b1);
    checks++;
    if (s_busy !== 1'b1 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_busy: busy=%b valid=%b required 1 0", s_busy, s_valid);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h00006655 || s_keep !== 4'h3 || s_last !== 1'b1) begin
      failures++;
      $display("FAIL stall_next_word: valid=%b data=%h keep=%h last=%b required 1 00006655 3 1",
               s_valid, s_data, s_keep, s_last);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 8'h55, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h66, 1'b0, 1'b1);
    reset = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;
    drive_cycle(1'b1, 8'h77, 1'b1, 1'b1);
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: busy=%b valid=%b required 0 0", s_busy, s_valid);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h00000077 || s_keep !== 4'h1 || s_last !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_word: valid=%b data=%h keep=%h last=%b required 1 00000077 1 1",
               s_valid, s_data, s_keep, s_last);
    end
  endtask

  task automatic test_single_then_full();
    drive_cycle(1'b1, 8'hC1, 1'b1, 1'b1);
    drive_cycle(1'b1, 8'hD1, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h000000C1 || s_keep !== 4'h1 || s_last !== 1'b1) begin
      failures++;
      $display("FAIL single_byte: valid=%b data=%h keep=%h last=%b required 1 000000c1 1 1",
               s_valid, s_data, s_keep, s_last);
    end
    drive_cycle(1'b1, 8'hD2, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'hD3, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'hD4, 1'b1, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'hD4D3D2D1 || s_keep !== 4'hF || s_last !== 1'b1) begin
      failures++;
      $display("FAIL after_flush_word: valid=%b data=%h keep=%h last=%b required 1 d4d3d2d1 f 1",
               s_valid, s_data, s_keep, s_last);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Random traffic. The model keeps the bytes of the word being assembled and
  // a queue of finished words; the output register holds at most one.
  task automatic test_random();
    logic [7:0]  pend[$];
    logic [37:0] words[$];   // {last, keep[3:0], data[31:0]}
    logic [37:0] exp_word;
    logic [31:0] dw;
    logic [3:0]  kp;
    logic        v, l, rr, exp_ready, hold_chk;
    logic [7:0]  d;
    logic [37:0] held;
    int          guard;
    hold_chk = 1'b0;
    held     = '0;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      l  = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 2) != 0);
      exp_ready = (words.size() == 0) || rr;
      drive_cycle(v, d, l, rr);
      checks++;
      if (s_ready !== exp_ready || s_valid !== (words.size() != 0) ||
          s_busy !== (pend.size() != 0)) begin
        failures++;
        $display("FAIL rand_ctrl %0d: ready=%b valid=%b busy=%b required %b %b %b", n,
                 s_ready, s_valid, s_busy, exp_ready, words.size() != 0, pend.size() != 0);
      end
      if (hold_chk) begin
        checks++;
        if ({s_last, s_keep, s_data} !== held) begin
          failures++;
          $display("FAIL rand_stable %0d: got %h required %h", n, {s_last, s_keep, s_data}, held);
        end
      end
      hold_chk = 1'b0;
      if (words.size() != 0) begin
        exp_word = words[0];
        checks++;
        if ({s_last, s_keep, s_data} !== exp_word) begin
          failures++;
          $display("FAIL rand_word %0d: got %h required %h", n, {s_last, s_keep, s_data}, exp_word);
        end
        if (rr) void'(words.pop_front());
        else begin
          hold_chk = 1'b1;
          held     = exp_word;
        end
      end
      if (v && exp_ready) begin
        pend.push_back(d);
        if (pend.size() == LANES || l) begin
          dw = '0;
          kp = '0;
          for (int i = 0; i < pend.size(); i++) begin
            dw = dw | (32'(pend[i]) << (8 * i));
            kp[i] = 1'b1;
          end
          words.push_back({l, kp, dw});
          pend.delete();
        end
      end
    end
    // Flush whatever is left so the next check sees an idle DUT.
    guard = 0;
    while (words.size() != 0 && guard < 20) begin
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      exp_word = words.pop_front();
      checks++;
      if (s_valid !== 1'b1 || {s_last, s_keep, s_data} !== exp_word) begin
        failures++;
        $display("FAIL rand_drain: valid=%b got %h required 1 %h", s_valid,
                 {s_last, s_keep, s_data}, exp_word);
      end
      guard++;
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_single_then_full();
    reset = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
